// File: rtl/hi_sim_response_scheduler.sv
// ISO 14443A tag response sequencer: byte FIFO, FDT wait after reader pause, Manchester fc/16 load modulation.
// Define HI_SIM_PARITY_EN to append an odd-parity bit after every byte.
module hi_sim_response_scheduler #(
    parameter int BUF_DEPTH = 8,
    parameter int FDT_WIDTH = 12
) (
    input  logic                       ck_1356meg,
    input  logic                       rst_n,
    input  logic                       byte_valid,
    input  logic [7:0]                 byte_data,
    output logic                       byte_ready,
    input  logic                       start,
    input  logic                       abort,
    input  logic [FDT_WIDTH-1:0]       fdt,
    input  logic                       reader_field,
    output logic                       mod_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(BUF_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(BUF_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PAUSE,
        WAIT_FDT,
        SOF,
        DATA,
`ifdef HI_SIM_PARITY_EN
        PARITY,
`endif
        EOF,
        DONE
    } state_t;

    state_t state, state_next;

    logic [7:0]           mem [BUF_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [FDT_WIDTH-1:0] fdt_q, fdt_cnt;
    logic [6:0]           bc;
    logic [2:0]           bit_idx;
    logic [7:0]           shift;
`ifdef HI_SIM_PARITY_EN
    logic                 par_q;
`endif
    logic                 wr_en, pop, load_fdt, period_end;
    logic                 tx_active, in_frame, cur_bit, mod_next;

    assign byte_ready = (state == IDLE) && (fifo_count < DEPTH);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign wr_en      = byte_valid && byte_ready && !abort;
    assign period_end = (bc == 7'd127);

    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_fdt   = 1'b0;
        tx_active  = 1'b0;
        in_frame   = 1'b0;
        cur_bit    = 1'b0;
        case (state)
            IDLE: if (start && fifo_count != '0) begin
                state_next = WAIT_PAUSE;
                load_fdt   = 1'b1;
            end
            WAIT_PAUSE: if (!reader_field) state_next = WAIT_FDT;
            WAIT_FDT: if (reader_field && fdt_cnt == fdt_q) state_next = SOF;
            SOF: begin
                tx_active = 1'b1;
                in_frame  = 1'b1;
                cur_bit   = 1'b1;
                if (period_end) begin
                    state_next = DATA;
                    pop        = 1'b1;
                end
            end
            DATA: begin
                tx_active = 1'b1;
                in_frame  = 1'b1;
                cur_bit   = shift[0];
                if (period_end && bit_idx == 3'd7) begin
`ifdef HI_SIM_PARITY_EN
                    state_next = PARITY;
`else
                    if (fifo_count != '0) pop = 1'b1;
                    else                  state_next = EOF;
`endif
                end
            end
`ifdef HI_SIM_PARITY_EN
            PARITY: begin
                tx_active = 1'b1;
                in_frame  = 1'b1;
                cur_bit   = par_q;
                if (period_end) begin
                    if (fifo_count != '0) begin
                        state_next = DATA;
                        pop        = 1'b1;
                    end else begin
                        state_next = EOF;
                    end
                end
            end
`endif
            EOF: begin
                in_frame = 1'b1;
                if (period_end) state_next = DONE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Logic 1 modulates the first half-bit, logic 0 the second; bc[3] gives the fc/16 subcarrier.
        mod_next = tx_active & (bc[6] ^ cur_bit) & ~bc[3];
        if (abort) begin
            state_next = IDLE;
            pop        = 1'b0;
            load_fdt   = 1'b0;
        end
    end

    always_ff @(posedge ck_1356meg) begin
        if (wr_en) mem[wr_ptr] <= byte_data;
    end

    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            mod_out    <= 1'b0;
            fdt_q      <= '0;
            fdt_cnt    <= '0;
            bc         <= '0;
            bit_idx    <= '0;
            shift      <= '0;
`ifdef HI_SIM_PARITY_EN
            par_q      <= 1'b0;
`endif
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            mod_out <= abort ? 1'b0 : mod_next;
            if (load_fdt) fdt_q <= fdt;
            // Any reader pause restarts the delay; the counter only runs while the field is up.
            if (abort || state != WAIT_FDT || !reader_field) fdt_cnt <= '0;
            else                                              fdt_cnt <= fdt_cnt + 1'b1;
            if (abort || !in_frame) bc <= '0;
            else                    bc <= bc + 7'd1;
            if (pop) begin
                shift   <= mem[rd_ptr];
                bit_idx <= '0;
`ifdef HI_SIM_PARITY_EN
                par_q   <= ~^mem[rd_ptr];
`endif
            end else if (state == DATA && period_end) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
            if (abort) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else if (wr_en) begin
                wr_ptr     <= wr_ptr + 1'b1;
                fifo_count <= fifo_count + 1'b1;
            end else if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hi_sim_response_scheduler.sv
// Bench for hi_sim_response_scheduler: FIFO vector table, decoded-frame scoreboard, abort and reset sequences.
module tb_hi_sim_response_scheduler;
    localparam int BUF_DEPTH = 8;
    localparam int FDT_WIDTH = 12;
`ifdef HI_SIM_PARITY_EN
    localparam int BPB = 9;
`else
    localparam int BPB = 8;
`endif

    logic                 ck;
    logic                 rst_n;
    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 byte_ready;
    logic                 start;
    logic                 abort;
    logic [FDT_WIDTH-1:0] fdt;
    logic                 reader_field;
    logic                 mod_out;
    logic                 busy;
    logic                 done;
    logic [3:0]           fifo_count;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       start;
        logic       abort;
        int         exp_count;
        logic       exp_ready;
        logic       exp_busy;
    } vec_t;

    vec_t       vecs [15];
    int         tests_run = 0;
    int         tests_failed = 0;
    logic       exp_bits [$];
    logic [7:0] tx_bytes [$];

    hi_sim_response_scheduler #(.BUF_DEPTH(BUF_DEPTH), .FDT_WIDTH(FDT_WIDTH)) dut (
        .ck_1356meg  (ck),
        .rst_n       (rst_n),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .start       (start),
        .abort       (abort),
        .fdt         (fdt),
        .reader_field(reader_field),
        .mod_out     (mod_out),
        .busy        (busy),
        .done        (done),
        .fifo_count  (fifo_count)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t make_vec(input logic v, input logic [7:0] d, input logic s, input logic a,
                                      input int cnt, input logic rdy, input logic bsy);
        vec_t r;
        r.valid = v; r.data = d; r.start = s; r.abort = a;
        r.exp_count = cnt; r.exp_ready = rdy; r.exp_busy = bsy;
        return r;
    endfunction

    task automatic apply_stimulus(input vec_t v, input int idx);
        byte_valid = v.valid;
        byte_data  = v.data;
        start      = v.start;
        abort      = v.abort;
        step();
        byte_valid = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        check_output($sformatf("vec%0d_count", idx), 32'(fifo_count), v.exp_count);
        check_output($sformatf("vec%0d_ready", idx), 32'(byte_ready), 32'(v.exp_ready));
        check_output($sformatf("vec%0d_busy", idx), 32'(busy), 32'(v.exp_busy));
        check_output($sformatf("vec%0d_done", idx), 32'(done), 0);
        check_output($sformatf("vec%0d_mod", idx), 32'(mod_out), 0);
    endtask

    // Loads tx_bytes, queues the expected bit stream, commits, drives the reader pause(s), waits for SOF.
    task automatic start_frame(input int fdt_val, input bit second_pause, output int lat);
        exp_bits.delete();
        exp_bits.push_back(1'b1);
        foreach (tx_bytes[i]) begin
            byte_valid = 1'b1;
            byte_data  = tx_bytes[i];
            for (int b = 0; b < 8; b++) exp_bits.push_back(tx_bytes[i][b]);
`ifdef HI_SIM_PARITY_EN
            exp_bits.push_back(~^tx_bytes[i]);
`endif
            step();
        end
        byte_valid = 1'b0;
        check_output("fifo_loaded", 32'(fifo_count), tx_bytes.size());
        fdt   = fdt_val[FDT_WIDTH-1:0];
        start = 1'b1;
        step();
        start = 1'b0;
        check_output("busy_after_start", 32'(busy), 1);
        reader_field = 1'b0;
        repeat (40) step();
        reader_field = 1'b1;
        if (second_pause) begin
            repeat (500) step();
            reader_field = 1'b0;
            repeat (20) step();
            reader_field = 1'b1;
        end
        lat = -1;
        for (int k = 1; k <= 4200; k++) begin
            step();
            if (mod_out === 1'b1) begin
                lat = k - 1;
                break;
            end
        end
        check_output("sof_latency", lat, fdt_val + 1);
    endtask

    task automatic decode_frame();
        int idx = 0;
        int done_idx = -1;
        int done_cnt = 0;
        int bad_sub = 0;
        int eof_ones = 0;
        int h0, h1, dec;
        int nbits = exp_bits.size();
        for (int p = 0; p < nbits; p++) begin
            h0 = 0;
            h1 = 0;
            for (int c = 0; c < 128; c++) begin
                if (idx > 0) step();
                if (c < 64) h0 += int'(mod_out);
                else        h1 += int'(mod_out);
                if (done === 1'b1) begin
                    done_cnt++;
                    if (done_idx < 0) done_idx = idx;
                end
                idx++;
            end
            if (h0 + h1 != 32) bad_sub++;
            dec = (h0 > 0 && h1 == 0) ? 1 : ((h0 == 0 && h1 > 0) ? 0 : 2);
            check_output($sformatf("bit%0d", p), dec, 32'(exp_bits.pop_front()));
        end
        for (int c = 0; c < 128; c++) begin
            step();
            eof_ones += int'(mod_out);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = idx;
            end
            idx++;
        end
        check_output("eof_quiet", eof_ones, 0);
        check_output("subcarrier_shape", bad_sub, 0);
        check_output("done_time", done_idx + 1, 128 * (2 + BPB * tx_bytes.size()));
        check_output("done_pulses", done_cnt, 1);
        step();
        check_output("done_after", 32'(done), 0);
        check_output("busy_after_done", 32'(busy), 0);
        check_output("fifo_after_done", 32'(fifo_count), 0);
    endtask

    initial begin
        int lat;
        int target;
        int cnt_done;
        int cnt_mod;
        rst_n        = 1'b0;
        byte_valid   = 1'b0;
        byte_data    = 8'h00;
        start        = 1'b0;
        abort        = 1'b0;
        fdt          = '0;
        reader_field = 1'b1;
        #23 rst_n = 1'b1;
        step();
        check_output("rst_mod", 32'(mod_out), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_done", 32'(done), 0);
        check_output("rst_count", 32'(fifo_count), 0);
        check_output("rst_ready", 32'(byte_ready), 1);

        for (int i = 0; i < 9; i++)
            vecs[i] = make_vec(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, (i < 8) ? i + 1 : 8, (i < 7), 1'b0);
        vecs[9]  = make_vec(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        vecs[10] = make_vec(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        vecs[11] = make_vec(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        vecs[12] = make_vec(1'b1, 8'h77, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        vecs[13] = make_vec(1'b1, 8'hAA, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        vecs[14] = make_vec(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) apply_stimulus(vecs[i], i);

        tx_bytes = '{8'h44, 8'h00};
        start_frame(1172, 1'b0, lat);
        decode_frame();

        start_frame(1172, 1'b1, lat);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_output("pause2_abort_busy", 32'(busy), 0);
        check_output("pause2_abort_mod", 32'(mod_out), 0);

        tx_bytes = '{8'h5A, 8'hC3, 8'h81};
        start_frame(10, 1'b0, lat);
        target = (1 + BPB + 3) * 128 + 65;
        for (int i = 0; i < target; i++) step();
        check_output("count_before_abort", 32'(fifo_count), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_output("abort_mod", 32'(mod_out), 0);
        check_output("abort_busy", 32'(busy), 0);
        check_output("abort_count", 32'(fifo_count), 0);
        check_output("abort_ready", 32'(byte_ready), 1);
        cnt_done = 0;
        cnt_mod  = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            cnt_done += int'(done);
            cnt_mod  += int'(mod_out);
        end
        check_output("abort_no_done", cnt_done, 0);
        check_output("abort_no_mod", cnt_mod, 0);

        tx_bytes = '{8'h11, 8'h22, 8'h33};
        start_frame(3, 1'b0, lat);
        step();
        step();
        check_output("sof_mod_before_reset", 32'(mod_out), 1);
        check_output("sof_count_before_reset", 32'(fifo_count), 3);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_rst_mod", 32'(mod_out), 0);
        check_output("async_rst_busy", 32'(busy), 0);
        check_output("async_rst_done", 32'(done), 0);
        check_output("async_rst_count", 32'(fifo_count), 0);
        check_output("async_rst_ready", 32'(byte_ready), 1);
        #2 rst_n = 1'b1;
        step();
        check_output("post_rst_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
